// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-detecting enable controller for a latch-based clock gate.
// Removes the gated clock after IDLE_CYCLES consecutive idle samples and
// restores it on activity, acknowledging once WAKE_CYCLES stable cycles pass.
// Optional feature macro: CLK_GATE_CTRL_FORCE_ON_EN adds the i_force_on override.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_busy,
    input  logic       i_wake_req,
`ifdef CLK_GATE_CTRL_FORCE_ON_EN
    input  logic       i_force_on,
`endif
    output logic       o_clk_en,
    output logic       o_wake_ack,
    output logic [1:0] o_state
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_GATED = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDLE_W-1:0]  idle_cnt_r;
    logic [IDLE_W-1:0]  idle_cnt_next_s;
    logic [WAKE_W-1:0]  wake_cnt_r;
    logic [WAKE_W-1:0]  wake_cnt_next_s;
    logic               clk_en_r;
    logic               clk_en_next_s;
    logic               wake_ack_r;
    logic               wake_ack_next_s;
    logic               force_s;
    logic               active_s;

`ifdef CLK_GATE_CTRL_FORCE_ON_EN
    assign force_s = i_force_on;
`else
    assign force_s = 1'b0;
`endif

    assign active_s = i_busy | i_wake_req | force_s;

    // Next-state, counter and output decode; outputs follow the next state so
    // the registered versions change together with the state.
    always_comb begin
        state_next_s    = state_r;
        idle_cnt_next_s = idle_cnt_r;
        wake_cnt_next_s = wake_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (active_s) begin
                    idle_cnt_next_s = {IDLE_W{1'b0}};
                end else if (idle_cnt_r == IDLE_LAST) begin
                    state_next_s    = ST_GATED;
                    idle_cnt_next_s = {IDLE_W{1'b0}};
                end else begin
                    idle_cnt_next_s = idle_cnt_r + IDLE_ONE;
                end
            end
            ST_GATED: begin
                if (active_s) begin
                    state_next_s    = ST_WAKE;
                    wake_cnt_next_s = {WAKE_W{1'b0}};
                end else begin
                    state_next_s    = ST_GATED;
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion regardless of the inputs.
                if (wake_cnt_r == WAKE_LAST) begin
                    state_next_s    = ST_RUN;
                    wake_cnt_next_s = {WAKE_W{1'b0}};
                end else begin
                    wake_cnt_next_s = wake_cnt_r + WAKE_ONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to the clock-on state.
                state_next_s    = ST_RUN;
                idle_cnt_next_s = {IDLE_W{1'b0}};
                wake_cnt_next_s = {WAKE_W{1'b0}};
            end
        endcase

        clk_en_next_s   = (state_next_s != ST_GATED);
        wake_ack_next_s = (state_next_s == ST_RUN);
    end

    // State, counters and registered outputs; reset forces the clock on at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_RUN;
            idle_cnt_r <= {IDLE_W{1'b0}};
            wake_cnt_r <= {WAKE_W{1'b0}};
            clk_en_r   <= 1'b1;
            wake_ack_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            idle_cnt_r <= idle_cnt_next_s;
            wake_cnt_r <= wake_cnt_next_s;
            clk_en_r   <= clk_en_next_s;
            wake_ack_r <= wake_ack_next_s;
        end
    end

    assign o_clk_en   = clk_en_r;
    assign o_wake_ack = wake_ack_r;
    assign o_state    = state_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2).
// Directed scenarios followed by a randomized run, all compared each cycle
// against a behavioural model kept as an idle-run length and a wake countdown.
module tb_clk_gate_ctrl;

    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       wake_req;
    logic       force_on;
    logic       clk_en;
    logic       wake_ack;
    logic [1:0] state;

    int checks;
    int errors;

    // Behavioural model
    int m_gated;
    int m_wake_left;
    int m_idle_run;

    clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_busy     (busy),
        .i_wake_req (wake_req),
`ifdef CLK_GATE_CTRL_FORCE_ON_EN
        .i_force_on (force_on),
`endif
        .o_clk_en   (clk_en),
        .o_wake_ack (wake_ack),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gated     = 0;
        m_wake_left = 0;
        m_idle_run  = 0;
    endtask

    task automatic model_edge(input logic act);
        if (m_wake_left > 0) begin
            m_wake_left = m_wake_left - 1;
        end else if (m_gated != 0) begin
            if (act) begin
                m_gated     = 0;
                m_wake_left = WAKE;
            end
        end else begin
            if (act) m_idle_run = 0;
            else     m_idle_run = m_idle_run + 1;
            if (m_idle_run == IDLE) begin
                m_gated    = 1;
                m_idle_run = 0;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        logic [1:0] e_state;
        e_state = (m_gated != 0) ? 2'b10 : ((m_wake_left > 0) ? 2'b01 : 2'b00);
        chk({tag, ".clk_en"},   {1'b0, clk_en},   {1'b0, (m_gated == 0)});
        chk({tag, ".wake_ack"}, {1'b0, wake_ack}, {1'b0, (m_gated == 0) && (m_wake_left == 0)});
        chk({tag, ".state"},    state,            e_state);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic step(input logic b, input logic w, input logic f, input string tag);
        busy     = b;
        wake_req = w;
        force_on = f;
        @(posedge clk);
`ifdef CLK_GATE_CTRL_FORCE_ON_EN
        model_edge(b | w | f);
`else
        model_edge(b | w);
`endif
        #1;
        chk_model(tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
    endtask

    // Reset asserted mid-cycle; outputs must respond before any edge.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_clk_en"}, {1'b0, clk_en},   2'b01);
        chk({tag, ".rst_ack"},    {1'b0, wake_ack}, 2'b01);
        chk({tag, ".rst_state"},  state,            2'b00);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        busy     = 1'b0;
        wake_req = 1'b0;
        force_on = 1'b0;
        model_reset();
        #1;
        chk("por.clk_en", {1'b0, clk_en},   2'b01);
        chk("por.ack",    {1'b0, wake_ack}, 2'b01);
        chk("por.state",  state,            2'b00);
        #6;
        rst = 1'b0;

        // 15 idle then busy: no gating
        idle_steps(IDLE - 1, "idle15");
        step(1'b1, 1'b0, 1'b0, "busy_after15");
        chk("no_gate15", {1'b0, clk_en}, 2'b01);

        // 16 idle: gate after the 16th edge
        idle_steps(IDLE - 1, "idle_a");
        chk("pre_gate", state, 2'b00);
        step(1'b0, 1'b0, 1'b0, "idle16");
        chk("gated.state",  state,            2'b10);
        chk("gated.clk_en", {1'b0, clk_en},   2'b00);

        // Wake request: clk_en after n, ack after n+2
        step(1'b0, 1'b1, 1'b0, "wake_n");
        chk("wake_n.clk_en", {1'b0, clk_en},   2'b01);
        chk("wake_n.ack",    {1'b0, wake_ack}, 2'b00);
        step(1'b0, 1'b1, 1'b0, "wake_n1");
        chk("wake_n1.ack",   {1'b0, wake_ack}, 2'b00);
        step(1'b0, 1'b1, 1'b0, "wake_n2");
        chk("wake_n2.ack",   {1'b0, wake_ack}, 2'b01);

        // Drop request: re-gate 16 edges later
        idle_steps(IDLE - 1, "regate");
        chk("regate15", state, 2'b00);
        step(1'b0, 1'b0, 1'b0, "regate16");
        chk("regate16.state", state, 2'b10);

        // Single-cycle busy blip in GATED causes a full wake
        step(1'b1, 1'b0, 1'b0, "blip");
        idle_steps(WAKE, "blip_wake");
        chk("blip_run", state, 2'b00);
        idle_steps(IDLE - 1, "blip_idle");
        step(1'b1, 1'b0, 1'b0, "simul16");
        chk("simul.clk_en", {1'b0, clk_en}, 2'b01);
        chk("simul.state",  state,          2'b00);
        idle_steps(IDLE - 1, "simul_recount");
        chk("simul_recount", state, 2'b00);
        step(1'b0, 1'b0, 1'b0, "simul_gate");
        chk("simul_gate.state", state, 2'b10);

        // Reset mid-WAKE, then counting restarts from zero
        step(1'b0, 1'b1, 1'b0, "rw_req");
        step(1'b0, 1'b1, 1'b0, "rw_n1");
        mid_reset("rw");
        idle_steps(IDLE - 1, "rw_idle");
        chk("rw_idle15", state, 2'b00);
        step(1'b0, 1'b0, 1'b0, "rw_idle16");
        chk("rw_gate", state, 2'b10);

`ifdef CLK_GATE_CTRL_FORCE_ON_EN
        step(1'b1, 1'b0, 1'b0, "f_wake");
        idle_steps(WAKE, "f_wake_done");
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, "force_hold");
        chk("force_nogate", state, 2'b00);
        idle_steps(IDLE, "force_idle");
        chk("force_gated", state, 2'b10);
        step(1'b0, 1'b0, 1'b1, "force_wake");
        step(1'b0, 1'b0, 1'b1, "force_w1");
        chk("force_w1.ack", {1'b0, wake_ack}, 2'b00);
        step(1'b0, 1'b0, 1'b0, "force_w2");
        chk("force_w2.ack", {1'b0, wake_ack}, 2'b01);
`endif

        // Randomized run with sparse activity so gating happens often
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset("rnd");
            end else begin
                step(($urandom_range(0, 24) == 0),
                     ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 59) == 0),
                     "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
